// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V main control FSM:
// state codes, major opcodes and ALU operand-B select codes.
package riscv_ctrl_pkg;

  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_EXEC_R  = 4'd2;
  localparam logic [3:0] ST_EXEC_I  = 4'd3;
  localparam logic [3:0] ST_ALU_WB  = 4'd4;
  localparam logic [3:0] ST_MEMADR  = 4'd5;
  localparam logic [3:0] ST_MEMRD   = 4'd6;
  localparam logic [3:0] ST_LOAD_WB = 4'd7;
  localparam logic [3:0] ST_MEMWR   = 4'd8;
  localparam logic [3:0] ST_BRANCH  = 4'd9;
  localparam logic [3:0] ST_ILLEGAL = 4'd10;

  typedef enum logic [3:0] {
    FETCH   = ST_FETCH,
    DECODE  = ST_DECODE,
    EXEC_R  = ST_EXEC_R,
    EXEC_I  = ST_EXEC_I,
    ALU_WB  = ST_ALU_WB,
    MEMADR  = ST_MEMADR,
    MEMRD   = ST_MEMRD,
    LOAD_WB = ST_LOAD_WB,
    MEMWR   = ST_MEMWR,
    BRANCH  = ST_BRANCH,
    ILLEGAL = ST_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_main_control.sv
// Moore main-control FSM for the multi-cycle RISC-V datapath with a retired-instruction counter.
// Optional feature: ILLEGAL_TRAP_EN makes illegal opcodes trap and halt until reset.
module multicycle_main_control
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 IorD,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 PCSource,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 ALUOp0,
  output logic                 ALUOp1,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic [INSTRET_W-1:0] instret,
  output logic                 trap
);

  state_t state, next_state;
  logic   retire;

  // The branch decision is made in the datapath via PCWriteCond & zero.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    retire      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RS2;
    ALUOp0      = 1'b0;
    ALUOp1      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    unique case (state)
      FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM;
        unique case (opcode)
          OP_RTYPE:           next_state = EXEC_R;
          OP_IMM:             next_state = EXEC_I;
          OP_LOAD, OP_STORE:  next_state = MEMADR;
          OP_BRANCH:          next_state = BRANCH;
          default:            next_state = ILLEGAL;
        endcase
      end
      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUOp0     = 1'b1;
        next_state = ALU_WB;
      end
      EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUOp0     = 1'b1;
        next_state = ALU_WB;
      end
      ALU_WB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = (opcode == OP_LOAD) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) next_state = LOAD_WB;
      end
      LOAD_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp1      = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        retire      = 1'b1;
        next_state  = FETCH;
      end
      ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        next_state = ILLEGAL;
`else
        retire     = 1'b1;
        next_state = FETCH;
`endif
      end
      default: next_state = FETCH;
    endcase
  end

  // Counter wraps naturally at 2^INSTRET_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instret <= '0;
    else if (retire) instret <= instret + INSTRET_W'(1);
  end

`ifdef ILLEGAL_TRAP_EN
  // Set on entry so trap is visible in the first ILLEGAL cycle.
  logic trap_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      trap_q <= 1'b0;
    else if (next_state == ILLEGAL) trap_q <= 1'b1;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed table-driven bench for multicycle_main_control (4-bit instret to exercise wrap).
// Expectations for the illegal opcode follow ILLEGAL_TRAP_EN when it is defined.
module tb_multicycle_main_control;

  localparam int IW = 4;

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_LD  = 7'b0000011;
  localparam logic [6:0] T_ST  = 7'b0100011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_ILL = 7'b1111111;

  // {mem_req,mem_we,IorD,IRWrite,PCWrite,PCWriteCond,PCSource,ALUSrcA,ALUSrcB[1:0],ALUOp0,ALUOp1,MemtoReg,RegWrite}
  localparam logic [13:0] P_FWAIT = 14'b1_0_0_0_0_0_0_0_01_0_0_0_0;
  localparam logic [13:0] P_FRDY  = 14'b1_0_0_1_1_0_0_0_01_0_0_0_0;
  localparam logic [13:0] P_DEC   = 14'b0_0_0_0_0_0_0_0_10_0_0_0_0;
  localparam logic [13:0] P_EXR   = 14'b0_0_0_0_0_0_0_1_00_1_0_0_0;
  localparam logic [13:0] P_EXI   = 14'b0_0_0_0_0_0_0_1_10_1_0_0_0;
  localparam logic [13:0] P_AWB   = 14'b0_0_0_0_0_0_0_0_00_0_0_0_1;
  localparam logic [13:0] P_MADR  = 14'b0_0_0_0_0_0_0_1_10_0_0_0_0;
  localparam logic [13:0] P_MRD   = 14'b1_0_1_0_0_0_0_0_00_0_0_0_0;
  localparam logic [13:0] P_LWB   = 14'b0_0_0_0_0_0_0_0_00_0_0_1_1;
  localparam logic [13:0] P_MWR   = 14'b1_1_1_0_0_0_0_0_00_0_0_0_0;
  localparam logic [13:0] P_BR    = 14'b0_0_0_0_0_1_1_1_00_0_1_0_0;
  localparam logic [13:0] P_ZERO  = 14'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          zero, mem_ready;
  logic          mem_req, mem_we, IorD, IRWrite, PCWrite, PCWriteCond, PCSource;
  logic          ALUSrcA, ALUOp0, ALUOp1, MemtoReg, RegWrite, trap;
  logic [1:0]    ALUSrcB;
  logic [IW-1:0] instret;
  logic [13:0]   outv;

  int checks = 0;
  int failures = 0;
  logic rw_watch = 1'b0;
  logic rw_seen = 1'b0;

  multicycle_main_control #(.INSTRET_W(IW)) dut (
    .clk(clk), .reset(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp0(ALUOp0), .ALUOp1(ALUOp1), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .instret(instret), .trap(trap)
  );

  always #5 clk = ~clk;

  assign outv = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
                 ALUSrcA, ALUSrcB, ALUOp0, ALUOp1, MemtoReg, RegWrite};

  always @(posedge clk) if (rw_watch && RegWrite) rw_seen <= 1'b1;

  typedef struct {
    logic [6:0]    op;
    logic          z;
    logic          rdy;
    logic [13:0]   exp;
    logic [IW-1:0] ei;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [6:0] op, input logic z, input logic rdy,
                     input logic [13:0] exp, input logic [IW-1:0] ei);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.exp = exp; v.ei = ei;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle: drive on the falling edge, compare mid-low-phase, before the next rise.
  task automatic cyc(input logic [6:0] op, input logic z, input logic rdy,
                     input logic [13:0] exp, input logic [IW-1:0] ei, input string name);
    @(negedge clk);
    opcode = op; zero = z; mem_ready = rdy;
    #1;
    chk({name, "_out"}, 32'(outv), 32'(exp));
    chk({name, "_instret"}, 32'(instret), 32'(ei));
  endtask

  task automatic rtype(input logic [IW-1:0] ei, input string name);
    cyc(T_R, 1'b0, 1'b1, P_FRDY, ei, {name, "_f"});
    cyc(T_R, 1'b0, 1'b1, P_DEC,  ei, {name, "_d"});
    cyc(T_R, 1'b0, 1'b1, P_EXR,  ei, {name, "_x"});
    cyc(T_R, 1'b0, 1'b1, P_AWB,  ei, {name, "_w"});
  endtask

  initial begin
    logic [IW-1:0] base;
    rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    #3;
    chk("reset_out", 32'(outv), 32'(P_FWAIT));
    chk("reset_instret", 32'(instret), 32'd0);
    chk("reset_trap", 32'(trap), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_hold_out", 32'(outv), 32'(P_FWAIT));
    rst = 1'b0;

    // R-type
    add(T_R, 0, 1, P_FRDY, 0); add(T_R, 0, 1, P_DEC, 0);
    add(T_R, 0, 1, P_EXR, 0);  add(T_R, 0, 1, P_AWB, 0);
    // I-type
    add(T_I, 0, 1, P_FRDY, 1); add(T_I, 0, 1, P_DEC, 1);
    add(T_I, 0, 1, P_EXI, 1);  add(T_I, 0, 1, P_AWB, 1);
    // Load: fetch waits once, MEMRD waits three cycles
    add(T_LD, 0, 0, P_FWAIT, 2); add(T_LD, 0, 1, P_FRDY, 2);
    add(T_LD, 0, 1, P_DEC, 2);   add(T_LD, 0, 1, P_MADR, 2);
    add(T_LD, 0, 0, P_MRD, 2);   add(T_LD, 0, 0, P_MRD, 2);
    add(T_LD, 0, 0, P_MRD, 2);   add(T_LD, 0, 1, P_MRD, 2);
    add(T_LD, 0, 1, P_LWB, 2);
    // Store with one wait
    add(T_ST, 0, 1, P_FRDY, 3); add(T_ST, 0, 1, P_DEC, 3);
    add(T_ST, 0, 1, P_MADR, 3); add(T_ST, 0, 0, P_MWR, 3);
    add(T_ST, 0, 1, P_MWR, 3);
    // BEQ taken and not taken look identical to the FSM
    add(T_BEQ, 1, 1, P_FRDY, 4); add(T_BEQ, 1, 1, P_DEC, 4); add(T_BEQ, 1, 1, P_BR, 4);
    add(T_BEQ, 0, 1, P_FRDY, 5); add(T_BEQ, 0, 1, P_DEC, 5); add(T_BEQ, 0, 1, P_BR, 5);
    add(T_R, 0, 0, P_FWAIT, 6);

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].op, tbl[i].z, tbl[i].rdy, tbl[i].exp, tbl[i].ei, $sformatf("vec%0d", i));

    // Illegal opcode
    cyc(T_ILL, 1'b0, 1'b1, P_FRDY, 6, "ill_fetch");
    cyc(T_ILL, 1'b0, 1'b1, P_DEC,  6, "ill_dec");
    cyc(T_ILL, 1'b0, 1'b1, P_ZERO, 6, "ill_state");
`ifdef ILLEGAL_TRAP_EN
    chk("ill_trap", 32'(trap), 32'd1);
    for (int k = 0; k < 3; k++) cyc(T_R, 1'b0, 1'b1, P_ZERO, 6, $sformatf("ill_stuck%0d", k));
    chk("ill_trap_sticky", 32'(trap), 32'd1);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("ill_reset_trap", 32'(trap), 32'd0);
    @(negedge clk); rst = 1'b0;
    base = 0;
`else
    chk("ill_notrap", 32'(trap), 32'd0);
    cyc(T_R, 1'b0, 1'b0, P_FWAIT, 7, "ill_back");
    chk("ill_notrap_after", 32'(trap), 32'd0);
    base = 7;
`endif

    // Asynchronous reset while MEMRD waits on memory
    rw_seen = 1'b0; rw_watch = 1'b1;
    cyc(T_LD, 1'b0, 1'b1, P_FRDY, base, "ar_fetch");
    cyc(T_LD, 1'b0, 1'b1, P_DEC,  base, "ar_dec");
    cyc(T_LD, 1'b0, 1'b1, P_MADR, base, "ar_madr");
    cyc(T_LD, 1'b0, 1'b0, P_MRD,  base, "ar_wait0");
    cyc(T_LD, 1'b0, 1'b0, P_MRD,  base, "ar_wait1");
    @(negedge clk);
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_abort_out", 32'(outv), 32'(P_FWAIT));
    chk("ar_abort_instret", 32'(instret), 32'd0);
    @(negedge clk);
    chk("ar_held_out", 32'(outv), 32'(P_FWAIT));
    rst = 1'b0;
    cyc(T_R, 1'b0, 1'b1, P_FRDY, 0, "ar_refetch");
    rw_watch = 1'b0;
    chk("ar_no_regwrite", 32'(rw_seen), 32'd0);
    cyc(T_R, 1'b0, 1'b1, P_DEC, 0, "ar_dec2");
    cyc(T_R, 1'b0, 1'b1, P_EXR, 0, "ar_exr2");
    cyc(T_R, 1'b0, 1'b1, P_AWB, 0, "ar_awb2");

    // Counter wrap at 2^IW
    for (int n = 1; n < 16; n++) rtype(IW'(n), $sformatf("wrap%0d", n));
    cyc(T_R, 1'b0, 1'b0, P_FWAIT, 0, "wrap_to_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
